seq_feed_ctrl: RTL and testbench

- Sequencing controller for a 1-bit serial Moore sequence detector (ports: in, out, out_state, async active-low reset).
- On start, it clears the detector, shifts a parallel test word into it MSB-first, one bit per clock, and counts detector hits.
- Reports busy, a one-cycle done pulse and the hit count.
- Sits between a lab control panel (switches/buttons) and the detector instance.

---
 rtl/seq_feed_pkg.sv | 17 +
 rtl/seq_feed_shift.sv | 38 +++
 rtl/seq_feed_ctrl.sv | 117 +++++++++++
 tb/tb_seq_feed_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/seq_feed_pkg.sv
// Shared types and defaults for the serial-detector feed controller.
// Holds the FSM state encoding and the parameter defaults used by all blocks.
package seq_feed_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int   DEF_WIDTH      = 8;
  localparam int   DEF_CNT_W      = 4;
  localparam logic DEF_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/seq_feed_shift.sv
// Parallel-load, MSB-first shift register with bit index and last-bit flag.
// Load or shift takes effect on the next edge; no backpressure, driven by the FSM.
module seq_feed_shift
  import seq_feed_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] pattern,
  output logic             msb,
  output logic             last_bit
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] sreg;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
      idx  <= '0;
    end else if (load) begin
      sreg <= pattern;
      idx  <= '0;
    end else if (shift) begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
      idx  <= idx + IDX_W'(1);
    end
  end

  assign msb      = sreg[WIDTH-1];
  assign last_bit = (idx == IDX_W'(WIDTH - 1));

endmodule

// File: rtl/seq_feed_ctrl.sv
// Feeds a test word MSB-first into a Moore sequence detector and counts its hits.
// done pulses WIDTH+2 edges after start is accepted; start is ignored while busy. Option: SEQ_FEED_HITMAP_EN.
module seq_feed_ctrl
  import seq_feed_pkg::*;
#(
  parameter int   WIDTH      = DEF_WIDTH,
  parameter int   CNT_W      = DEF_CNT_W,
  parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  output logic             det_in,
  output logic             det_rst,
  input  logic             det_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count
`ifdef SEQ_FEED_HITMAP_EN
  ,
  output logic [WIDTH-1:0] hit_map
`endif
);

  state_t state;
  logic   cnt_en;
  logic   accept;
  logic   sh_msb;
  logic   last_bit;

  assign accept = (state == IDLE) && start;

  seq_feed_shift #(.WIDTH(WIDTH)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift    (state == SHIFT),
    .pattern  (pattern),
    .msb      (sh_msb),
    .last_bit (last_bit)
  );

  assign det_in = (state == SHIFT) ? sh_msb : IDLE_LEVEL;

  // Outputs are registered for the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      det_rst <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          det_rst <= 1'b1;
          if (start) begin
            state   <= LOAD;
            det_rst <= 1'b0;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          state   <= SHIFT;
          det_rst <= 1'b1;
        end
        SHIFT: begin
          if (last_bit) state <= DRAIN;
        end
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          det_rst <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // cnt_en lags SHIFT by one cycle to match the detector's output latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_en    <= 1'b0;
      hit_count <= '0;
    end else begin
      cnt_en <= (state == SHIFT);
      if (accept) begin
        hit_count <= '0;
      end else if (cnt_en && det_out && (hit_count != '1)) begin
        hit_count <= hit_count + CNT_W'(1);
      end
    end
  end

`ifdef SEQ_FEED_HITMAP_EN
  // One shift per counting cycle lands bit k's hit at position WIDTH-1-k.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_map <= '0;
    end else if (accept) begin
      hit_map <= '0;
    end else if (cnt_en) begin
      hit_map <= {hit_map[WIDTH-2:0], det_out};
    end
  end
`endif

endmodule

// File: tb/tb_seq_feed_ctrl.sv
// Bench for seq_feed_ctrl: two instances (CNT_W=4 and CNT_W=1) each driving an overlapping "101" Moore detector.
// Expected results come from substring counting on the fed pattern and a cycle timeline.
module tb_seq_feed_ctrl;

  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] pattern;

  logic       det_in0, det_rst0, det_out0, busy0, done0;
  logic [3:0] hit_count0;
  logic       det_in1, det_rst1, det_out1, busy1, done1;
  logic [0:0] hit_count1;
`ifdef SEQ_FEED_HITMAP_EN
  logic [7:0] hit_map0, hit_map1;
`endif

  int vectors     = 0;
  int miscompares = 0;

  seq_feed_ctrl #(.WIDTH(W), .CNT_W(4), .IDLE_LEVEL(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern),
    .det_in(det_in0), .det_rst(det_rst0), .det_out(det_out0),
    .busy(busy0), .done(done0), .hit_count(hit_count0)
`ifdef SEQ_FEED_HITMAP_EN
    , .hit_map(hit_map0)
`endif
  );

  seq_feed_ctrl #(.WIDTH(W), .CNT_W(1), .IDLE_LEVEL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern),
    .det_in(det_in1), .det_rst(det_rst1), .det_out(det_out1),
    .busy(busy1), .done(done1), .hit_count(hit_count1)
`ifdef SEQ_FEED_HITMAP_EN
    , .hit_map(hit_map1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Overlapping "101" Moore detector: 0 idle, 1 saw 1, 2 saw 10, 3 saw 101.
  function automatic logic [1:0] det_nxt(input logic [1:0] s, input logic b);
    case (s)
      2'd0:    return b ? 2'd1 : 2'd0;
      2'd1:    return b ? 2'd1 : 2'd2;
      2'd2:    return b ? 2'd3 : 2'd0;
      default: return b ? 2'd1 : 2'd2;
    endcase
  endfunction

  logic [1:0] d_st0, d_st1;
  always @(posedge clk or negedge det_rst0)
    if (!det_rst0) d_st0 <= 2'd0; else d_st0 <= det_nxt(d_st0, det_in0);
  always @(posedge clk or negedge det_rst1)
    if (!det_rst1) d_st1 <= 2'd0; else d_st1 <= det_nxt(d_st1, det_in1);
  assign det_out0 = (d_st0 == 2'd3);
  assign det_out1 = (d_st1 == 2'd3);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hits = occurrences of "101" in the MSB-first bit stream; a hit ending at bit k maps to W-1-k.
  task automatic ref_model(input logic [7:0] p, output int n, output logic [7:0] m);
    n = 0;
    m = '0;
    for (int k = 2; k < W; k++) begin
      if (p[W+1-k] && !p[W-k] && p[W-1-k]) begin
        n++;
        m[W-1-k] = 1'b1;
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_det_rst0"}, det_rst0, 0);
    chk({tag, "_det_rst1"}, det_rst1, 0);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_done"}, done0, 0);
    chk({tag, "_hit0"}, hit_count0, 0);
    chk({tag, "_hit1"}, hit_count1, 0);
    chk({tag, "_det_in"}, det_in0, 1);
`ifdef SEQ_FEED_HITMAP_EN
    chk({tag, "_map"}, hit_map0, 0);
`endif
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge of the first idle cycle after DONE.
  task automatic run(input logic [7:0] pat, input bit hold, input bit noise);
    int         eh;
    logic [7:0] emap;
    int         sat0, sat1;
    ref_model(pat, eh, emap);
    sat0 = (eh > 15) ? 15 : eh;
    sat1 = (eh > 1) ? 1 : eh;
    pattern = pat;
    start   = 1'b1;
    @(posedge clk);
    #1;
    pattern = 8'($urandom);
    if (!hold) start = 1'b0;
    for (int c = 0; c <= W + 3; c++) begin
      @(negedge clk);
      chk("busy", busy0, (c <= W + 2) ? 1 : 0);
      chk("busy_c1", busy1, (c <= W + 2) ? 1 : 0);
      chk("done", done0, (c == W + 2) ? 1 : 0);
      chk("det_rst", det_rst0, (c != 0) ? 1 : 0);
      chk("det_in", det_in0, (c >= 1 && c <= W) ? pat[W-c] : 1'b1);
      if (c >= W + 2) begin
        chk("hit_count", hit_count0, sat0);
        chk("hit_count_c1", hit_count1, sat1);
`ifdef SEQ_FEED_HITMAP_EN
        chk("hit_map", hit_map0, emap);
        chk("hit_map_c1", hit_map1, emap);
`endif
      end
      if (noise && c == 4) begin
        start   = 1'b1;
        pattern = ~pat;
      end else if (noise && c == 5 && !hold) begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    pattern = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b1;
    @(negedge clk);
    chk("idle_det_rst", det_rst0, 1);
    chk("idle_busy", busy0, 0);
    chk("idle_det_in", det_in0, 1);

    // Directed runs
    run(8'b10101000, 1'b0, 1'b0);
    run(8'hFF, 1'b0, 1'b0);
    run(8'b10101010, 1'b0, 1'b0);
    run(8'b10100101, 1'b0, 1'b1);
    run(8'b10110101, 1'b1, 1'b0);
    run(8'b01010101, 1'b1, 1'b0);
    start = 1'b0;
    @(negedge clk);

    // Abort mid-SHIFT (bit 4), then a fresh run
    pattern = 8'b11111111;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c <= 5; c++) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_vals("abort");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run(8'b10100000, 1'b0, 1'b0);

    // Randomized runs
    for (int i = 0; i < 20; i++) begin
      run(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("final_busy", busy0, 0);
    chk("final_done", done0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
